spi_config_regs: RTL and testbench

- SPI slave register bank sitting directly upstream of the pixel generator and audio source in the demoscene top level.
- Takes raw SCLK/SSEL/MOSI pins, resynchronises them into clk, and decodes a byte protocol.
- Holds 8 x 8-bit configuration registers, readable back over MISO.
- Presents them to the video/audio stages through a frame-synchronous shadow copy, so colour and scroll changes never tear mid-frame.

---
 rtl/spi_config_regs_if.sv | 10 +
 rtl/spi_config_regs.sv | 196 +++++++++++++++++++
 tb/tb_spi_config_regs.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_config_regs_if.sv
// SPI pin bundle between an SPI master and the configuration register bank.
interface spi_config_regs_if;
    logic SCLK;
    logic SSEL;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output SSEL, output MOSI, input MISO);
    modport slave  (input SCLK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_config_regs.sv
// SPI mode-0 slave register bank: resynchronises the SPI pins into clk,
// decodes {rw, addr} command bytes with auto-incrementing bursts and keeps a
// write bank plus a frame-synchronous active copy for the video/audio stages.
module spi_config_regs #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_config_regs_if.slave      spi,
    input  logic                  frame_sync,
    output logic [8*NUM_REGS-1:0] cfg_regs,
    output logic                  wr_strobe,
    output logic                  audio_en
);
    localparam int unsigned ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    // reg0 bit0 enables audio out of reset; everything else clears
    localparam logic [NUM_REGS-1:0][7:0] RESET_BANK = (8*NUM_REGS)'(8'h01);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_hist;
    logic                   ssel_hist;

    logic sclk_s;
    logic ssel_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ssel_fall;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [2:0]        cnt_q;
    logic [2:0]        cnt_d;
    logic [6:0]        rx_q;
    logic [6:0]        rx_d;
    logic [7:0]        tx_q;
    logic [7:0]        tx_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        rx_byte;
    logic              bank_we;
    logic              miso_q;
    logic              miso_d;

    logic [NUM_REGS-1:0][7:0] wbank_q;
    logic [NUM_REGS-1:0][7:0] active_q;

    // Input synchronisers plus one history flop for SCLK/SSEL edge detection.
    // Clearing the SSEL chain to 0 means a frame already in progress when
    // reset releases is never mistaken for a fresh SSEL falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            ssel_sync <= '0;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            ssel_hist <= 1'b0;
        end else begin
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi.SCLK);
            ssel_sync <= (ssel_sync << 1) | SYNC_STAGES'(spi.SSEL);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi.MOSI);
            sclk_hist <= sclk_s;
            ssel_hist <= ssel_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ssel_s    = ssel_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign ssel_fall = ~ssel_s & ssel_hist;

    assign rx_byte  = {rx_q, mosi_s};
    assign addr_inc = addr_q + ADDR_W'(1);

    // Protocol FSM next-state and datapath decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        bank_we = 1'b0;

        if (ssel_s) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ssel_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = 3'd0;
                        rx_d    = 7'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            addr_d = rx_byte[ADDR_W-1:0];
                            if (rx_byte[7]) begin
                                state_d = ST_RDATA;
                                tx_d    = wbank_q[rx_byte[ADDR_W-1:0]];
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        rx_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            bank_we = 1'b1;
                            addr_d  = addr_inc;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            tx_d   = wbank_q[addr_inc];
                            addr_d = addr_inc;
                        end
                    end else if (sclk_fall && (cnt_q != 3'd0)) begin
                        // the fall right after a load keeps bit 7 on MISO
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        miso_d = (state_d == ST_RDATA) ? tx_d[7] : 1'b0;
    end

    // Protocol FSM state and shift registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            rx_q    <= 7'd0;
            tx_q    <= 8'd0;
            addr_q  <= '0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            miso_q  <= miso_d;
        end
    end

    // Write bank, write strobe and frame-synchronous active copy; a write on
    // the frame_sync clk lands in the bank only, so active sees the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbank_q   <= RESET_BANK;
            active_q  <= RESET_BANK;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= bank_we;
            if (bank_we) begin
                wbank_q[addr_q] <= rx_byte;
            end
            if (frame_sync) begin
                active_q <= wbank_q;
            end
        end
    end

    assign cfg_regs = active_q;
    assign audio_en = active_q[0][0];
    assign spi.MISO = miso_q;

endmodule

// File: tb/tb_spi_config_regs.sv
// Bench for spi_config_regs: directed table, multi-cycle corner cases and
// randomized bursts checked against an array-based register model.
module tb_spi_config_regs;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 5;   // SCLK half period in clk cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [63:0] cfg_regs;
    logic        wr_strobe;
    logic        audio_en;

    spi_config_regs_if spi ();

    spi_config_regs #(
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi       (spi),
        .frame_sync(frame_sync),
        .cfg_regs  (cfg_regs),
        .wr_strobe (wr_strobe),
        .audio_en  (audio_en)
    );

    always #5 clk = ~clk;

    int n_checks    = 0;
    int n_fail      = 0;
    int strobe_cnt  = 0;
    int exp_strobes = 0;

    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    // Register model: write bank and active copy as plain arrays
    logic [7:0] wbank_m  [8];
    logic [7:0] active_m [8];

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [31:0] data;
        logic        sync;
        logic [63:0] exp_pre;
        logic [63:0] exp_post;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] active_vec();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = active_m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            wbank_m[i]  = 8'h00;
            active_m[i] = 8'h00;
        end
        wbank_m[0]  = 8'h01;
        active_m[0] = 8'h01;
    endtask

    task automatic model_sync();
        for (int i = 0; i < 8; i++) active_m[i] = wbank_m[i];
    endtask

    task automatic model_xact(input logic [7:0] cmd, input int n, input logic [31:0] data,
                              output logic [31:0] exp_rd);
        int a;
        a      = int'(cmd[2:0]);
        exp_rd = '0;
        for (int k = 0; k < n; k++) begin
            if (cmd[7]) begin
                exp_rd[31-8*k -: 8] = wbank_m[a];
            end else begin
                wbank_m[a] = data[31-8*k -: 8];
                exp_strobes++;
            end
            a = (a + 1) % 8;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi.MISO};
            spi.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.SCLK = 1'b0;
        end
    endtask

    task automatic sel_begin();
        spi.SSEL = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic sel_end();
        repeat (HALF) @(negedge clk);
        spi.SSEL = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        model_sync();
        repeat (2) @(negedge clk);
    endtask

    task automatic run_xact(input string tag, input logic [7:0] cmd, input int n,
                            input logic [31:0] data, output logic [31:0] rd);
        logic [7:0] cm;
        logic [7:0] b;
        sel_begin();
        spi_bits(cmd, 8, cm);
        check({tag, "_cmd_miso"}, 64'(cm), 64'h0);
        rd = '0;
        for (int k = 0; k < n; k++) begin
            spi_bits(data[31-8*k -: 8], 8, b);
            rd[31-8*k -: 8] = b;
        end
        sel_end();
        check({tag, "_idle_miso"}, 64'(spi.MISO), 64'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] erd;
        logic [7:0]  cm;
        logic [7:0]  cmd;
        logic [31:0] data;
        logic        rw;
        int          n;

        vecs[0] = '{8'h02, 1, 32'hA500_0000, 1'b1, 64'h0000_0000_0000_0001, 64'h0000_0000_00A5_0001, 32'h0};
        vecs[1] = '{8'h06, 3, 32'h1122_3300, 1'b1, 64'h0000_0000_00A5_0001, 64'h2211_0000_00A5_0033, 32'h0};
        vecs[2] = '{8'h86, 3, 32'hFFFF_FFFF, 1'b0, 64'h2211_0000_00A5_0033, 64'h2211_0000_00A5_0033, 32'h1122_3300};
        vecs[3] = '{8'h00, 1, 32'h0000_0000, 1'b1, 64'h2211_0000_00A5_0033, 64'h2211_0000_00A5_0000, 32'h0};
        vecs[4] = '{8'hF9, 2, 32'h0000_0000, 1'b0, 64'h2211_0000_00A5_0000, 64'h2211_0000_00A5_0000, 32'h00A5_0000};
        vecs[5] = '{8'h7F, 2, 32'h5AC3_0000, 1'b1, 64'h2211_0000_00A5_0000, 64'h5A11_0000_00A5_00C3, 32'h0};
        vecs[6] = '{8'h87, 2, 32'h0000_0000, 1'b0, 64'h5A11_0000_00A5_00C3, 64'h5A11_0000_00A5_00C3, 32'h5AC3_0000};

        spi.SCLK   = 1'b0;
        spi.SSEL   = 1'b1;
        spi.MOSI   = 1'b0;
        frame_sync = 1'b0;
        reset      = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        check("rst_cfg",    cfg_regs, 64'h0000_0000_0000_0001);
        check("rst_miso",   64'(spi.MISO), 64'h0);
        check("rst_audio",  64'(audio_en), 64'h1);
        check("rst_strobe", 64'(strobe_cnt), 64'h0);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            run_xact($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].n, vecs[v].data, rd);
            model_xact(vecs[v].cmd, vecs[v].n, vecs[v].data, erd);
            check($sformatf("vec%0d_rd", v), 64'(rd), 64'(vecs[v].exp_rd));
            check($sformatf("vec%0d_strobes", v), 64'(strobe_cnt), 64'(exp_strobes));
            check($sformatf("vec%0d_pre", v), cfg_regs, vecs[v].exp_pre);
            if (vecs[v].sync) pulse_frame();
            check($sformatf("vec%0d_post", v), cfg_regs, vecs[v].exp_post);
            check($sformatf("vec%0d_audio", v), 64'(audio_en), 64'(vecs[v].exp_post[0]));
        end

        // SSEL raised after 5 data bits of a write to reg3
        sel_begin();
        spi_bits(8'h03, 8, cm);
        spi_bits(8'hFF, 5, cm);
        sel_end();
        check("abort_strobes", 64'(strobe_cnt), 64'(exp_strobes));
        run_xact("abort_rd", 8'h83, 1, 32'h0, rd);
        model_xact(8'h83, 1, 32'h0, erd);
        check("abort_reg3", 64'(rd), 64'(erd));
        run_xact("abort_next", 8'h03, 1, 32'h7700_0000, rd);
        model_xact(8'h03, 1, 32'h7700_0000, erd);
        pulse_frame();
        check("abort_next_cfg", cfg_regs, active_vec());
        check("abort_next_strobes", 64'(strobe_cnt), 64'(exp_strobes));

        // Write to reg1 committing on the same clk as frame_sync:
        // the commit edge is SYNC_STAGES+1 clk edges after the 8th SCLK rise
        sel_begin();
        spi_bits(8'h01, 8, cm);
        spi_bits(8'h3C, 7, cm);
        spi.MOSI = 1'b0;
        repeat (HALF) @(negedge clk);
        spi.SCLK = 1'b1;
        repeat (SYNC_STAGES) @(negedge clk);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        check("coinc_strobe", 64'(wr_strobe), 64'h1);
        model_sync();
        wbank_m[1] = 8'h3C;
        exp_strobes++;
        repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
        spi.SCLK = 1'b0;
        sel_end();
        check("coinc_active_old", cfg_regs, active_vec());
        check("coinc_strobes", 64'(strobe_cnt), 64'(exp_strobes));
        pulse_frame();
        check("coinc_active_new", cfg_regs, active_vec());
        check("coinc_reg1", 64'(cfg_regs[15:8]), 64'h3C);

        // Reset in the middle of a write data byte
        sel_begin();
        spi_bits(8'h04, 8, cm);
        spi_bits(8'hEE, 3, cm);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rstmid_cfg",   cfg_regs, 64'h0000_0000_0000_0001);
        check("rstmid_miso",  64'(spi.MISO), 64'h0);
        check("rstmid_audio", 64'(audio_en), 64'h1);
        spi_bits(8'h70, 5, cm);
        spi_bits(8'h99, 8, cm);
        sel_end();
        check("rstmid_strobes", 64'(strobe_cnt), 64'(exp_strobes));
        pulse_frame();
        check("rstmid_cfg_after", cfg_regs, active_vec());
        run_xact("rstmid_rd0", 8'h80, 4, 32'h0, rd);
        model_xact(8'h80, 4, 32'h0, erd);
        check("rstmid_bank_lo", 64'(rd), 64'(erd));
        run_xact("rstmid_rd4", 8'h84, 4, 32'h0, rd);
        model_xact(8'h84, 4, 32'h0, erd);
        check("rstmid_bank_hi", 64'(rd), 64'(erd));

        // Randomized bursts against the model
        for (int t = 0; t < 25; t++) begin
            rw   = 1'($urandom_range(0, 1));
            n    = int'($urandom_range(1, 4));
            cmd  = {rw, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
            data = $urandom;
            run_xact($sformatf("rnd%0d", t), cmd, n, data, rd);
            model_xact(cmd, n, data, erd);
            check($sformatf("rnd%0d_rd", t), 64'(rd), 64'(erd));
            check($sformatf("rnd%0d_strobes", t), 64'(strobe_cnt), 64'(exp_strobes));
            if ($urandom_range(0, 2) == 0) begin
                pulse_frame();
                check($sformatf("rnd%0d_cfg", t), cfg_regs, active_vec());
                check($sformatf("rnd%0d_audio", t), 64'(audio_en), 64'(active_m[0][0]));
            end
        end
        pulse_frame();
        check("final_cfg", cfg_regs, active_vec());
        check("final_audio", 64'(audio_en), 64'(active_m[0][0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
